// File: rtl/cpu_pkg.sv
// Shared CPU types: the instruction-queue entry format and its default depth.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } iq_entry_t;

  localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/inst_queue.sv
// Decoupling FIFO between the I-cache read stage and decode; holds back fetch
// early enough that fetches already in flight in the cache always find room.
module inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int HOLD_MARGIN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_exc,
  output logic                     in_ready,
  output logic                     fetch_hold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW:0] HOLD_W  = (PW+1)'(HOLD_MARGIN);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  iq_entry_t     mem [DEPTH];
  iq_entry_t     head;
  logic          full, empty, push, pop;

  // Pointers carry a wrap bit so full and empty stay distinguishable.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push       = in_valid & ~full & ~flush;
    pop        = ~empty & out_ready & ~flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (in_valid & full & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= '{pc: in_pc, inst: in_inst, exc: in_exc};
  end

  always_comb begin
    head       = mem[rd_ptr_q[AW-1:0]];
    out_pc     = head.pc;
    out_inst   = head.inst;
    out_exc    = head.exc;
    out_valid  = ~empty;
    in_ready   = ~full;
    count      = wr_ptr_q - rd_ptr_q;
    fetch_hold = ({1'b0, count} + HOLD_W) >= DEPTH_W;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a queue-based model.
module tb_inst_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int HM    = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_exc, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, fetch_hold, out_valid, out_exc, overflow;
  logic [31:0] out_pc, out_inst;
  logic [3:0]  count;

  iq_entry_t   model_q[$];
  bit          model_ovf;
  bit          checking;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .HOLD_MARGIN(HM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc),
    .in_ready(in_ready), .fetch_hold(fetch_hold),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
    .count(count), .overflow(overflow)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit f, input bit v, input logic [31:0] pc,
                                input logic [31:0] inst, input bit exc, input bit rdy);
    rst = r; flush = f; in_valid = v; in_pc = pc; in_inst = inst; in_exc = exc; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of entries updated from the FIFO rules.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (flush) begin
      model_q.delete();
    end else begin
      if (in_valid && model_q.size() == DEPTH) model_ovf = 1'b1;
      if (in_valid && model_q.size() < DEPTH) begin
        if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
        model_q.push_back('{pc: in_pc, inst: in_inst, exc: in_exc});
      end else if (out_ready && model_q.size() > 0) begin
        void'(model_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check_output("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      check_output("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
      check_output("count", 32'(count), 32'(model_q.size()));
      check_output("fetch_hold", 32'(fetch_hold), 32'((DEPTH - model_q.size()) <= HM));
      check_output("overflow", 32'(overflow), 32'(model_ovf));
      if (model_q.size() > 0) begin
        check_output("out_pc", out_pc, model_q[0].pc);
        check_output("out_inst", out_inst, model_q[0].inst);
        check_output("out_exc", 32'(out_exc), 32'(model_q[0].exc));
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; checking = 0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    checking = 1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("lit_reset_valid", 32'(out_valid), 0);
    check_output("lit_reset_ready", 32'(in_ready), 1);
    check_output("lit_reset_hold", 32'(fetch_hold), 0);
    check_output("lit_reset_count", 32'(count), 0);
    check_output("lit_reset_ovf", 32'(overflow), 0);

    // Three boot-vector fetches, then drain in order.
    for (int i = 0; i < 3; i++)
      apply_stimulus(0, 0, 1, 32'hBFC00000 + 32'(4*i), 32'h1000_0000 + 32'(i), 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("lit_three_count", 32'(count), 3);
    check_output("lit_three_head", out_pc, 32'hBFC00000);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("lit_drain_pc1", out_pc, 32'hBFC00004);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("lit_drain_pc2", out_pc, 32'hBFC00008);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("lit_drain_empty", 32'(out_valid), 0);

    // Fill to full, watching the hold threshold, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(0, 0, 1, 32'h0000_1000 + 32'(4*i), $urandom, 0, 0);
      if (i == 3) check_output("lit_hold_after4", 32'(fetch_hold), 0);
      if (i == 4) check_output("lit_hold_after5", 32'(fetch_hold), 1);
    end
    check_output("lit_full_count", 32'(count), 8);
    check_output("lit_full_ready", 32'(in_ready), 0);
    apply_stimulus(0, 0, 1, 32'h0000_2000, 0, 0, 0);
    check_output("lit_ovf_set", 32'(overflow), 1);
    check_output("lit_ovf_count", 32'(count), 8);

    // Full with push and pop: only the pop happens, then both happen.
    apply_stimulus(0, 0, 1, 32'h0000_3000, 0, 0, 1);
    check_output("lit_full_pushpop", 32'(count), 7);
    check_output("lit_full_pop_head", out_pc, 32'h0000_1004);
    apply_stimulus(0, 0, 1, 32'h0000_3004, 0, 0, 1);
    check_output("lit_pushpop_count", 32'(count), 7);

    // Flush leaves overflow alone; reset clears it.
    apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    check_output("lit_flush_keeps_ovf", 32'(overflow), 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    check_output("lit_rst_clears_ovf", 32'(overflow), 0);

    // Flush beats a same-cycle push and pop.
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 0, 1, 32'h0000_4000 + 32'(4*i), 0, 0, 0);
    check_output("lit_four_count", 32'(count), 4);
    apply_stimulus(0, 1, 1, 32'hDEADBEEF, 0, 0, 1);
    check_output("lit_flush_count", 32'(count), 0);
    check_output("lit_flush_valid", 32'(out_valid), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("lit_flush_nopush", 32'(out_valid), 0);

    // Exception entries travel like any other.
    apply_stimulus(0, 0, 1, 32'h80000001, 32'hFFFF_FFFF, 1, 0);
    check_output("lit_exc_flag", 32'(out_exc), 1);
    check_output("lit_exc_pc", out_pc, 32'h80000001);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("lit_exc_popped", 32'(out_valid), 0);

    // Random traffic with varying push/pop rates across many pointer wraps.
    for (int i = 0; i < 400; i++) begin
      int push_bias;
      int pop_bias;
      push_bias = ((i / 50) % 2 == 0) ? 4 : 2;
      pop_bias  = ((i / 50) % 2 == 0) ? 2 : 4;
      apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, push_bias) != 0), $urandom, $urandom,
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, pop_bias) != 0));
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    checking = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
